// File: rtl/pmu_counter_bank_ft_pkg.sv
// Shared types and helpers for the PMU counter bank: event-select width,
// the per-bit TMR majority vote and the copy-mismatch classification.
package pmu_ft_pkg;

  typedef enum logic [1:0] {
    MISM_NONE   = 2'd0,
    MISM_CORR   = 2'd1,
    MISM_UNCORR = 2'd2
  } mism_e;

  function automatic int sel_w(input int n_events);
    return (n_events > 1) ? $clog2(n_events) : 1;
  endfunction

  function automatic logic tmr_vote(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/pmu_counter_bank_ft_if.sv
// Control/status bundle between the AHB PMU slave (master side) and the
// counter bank (slave side).
interface pmu_counter_bank_ft_if
  import pmu_ft_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 24,
  parameter int N_EVENTS   = 32,
  parameter int SEL_W      = sel_w(N_EVENTS)
);
  logic [N_EVENTS-1:0]             events_i;
  logic                            enable_i;
  logic                            clear_i;
  logic [N_COUNTERS*SEL_W-1:0]     ev_sel_i;
  logic [N_COUNTERS-1:0]           wr_en_i;
  logic [REG_WIDTH-1:0]            wr_data_i;
  logic [N_COUNTERS-1:0]           ovf_mask_i;
  logic [N_COUNTERS-1:0]           ovf_ack_i;
  logic                            ft_clr_i;
  logic [N_COUNTERS-1:0]           ft_inj_i;
  logic                            ft_inj_mode_i;
  logic [N_COUNTERS*REG_WIDTH-1:0] counters_o;
  logic [N_COUNTERS-1:0]           overflow_o;
  logic                            intr_overflow_o;
  logic                            intr_FT1_o;
  logic                            intr_FT2_o;

  modport master (
    output events_i, enable_i, clear_i, ev_sel_i, wr_en_i, wr_data_i,
           ovf_mask_i, ovf_ack_i, ft_clr_i, ft_inj_i, ft_inj_mode_i,
    input  counters_o, overflow_o, intr_overflow_o, intr_FT1_o, intr_FT2_o
  );

  modport slave (
    input  events_i, enable_i, clear_i, ev_sel_i, wr_en_i, wr_data_i,
           ovf_mask_i, ovf_ack_i, ft_clr_i, ft_inj_i, ft_inj_mode_i,
    output counters_o, overflow_o, intr_overflow_o, intr_FT1_o, intr_FT2_o
  );

endinterface

// File: rtl/pmu_counter_bank_ft_cell.sv
// One PMU counter: up to three storage copies, voted next-value mux,
// fault injection and copy-mismatch classification.
// Optional macro PMU_SCRUB_EN: a correctable mismatch rewrites all copies
// from the voted value on the following edge.
// With FT=0 copies b/c are constant zero and the vote collapses to copy a.
module pmu_tmr_cnt_cell
  import pmu_ft_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int FT        = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic                 wr_en_i,
  input  logic [REG_WIDTH-1:0] wr_data_i,
  input  logic                 inc_i,
  input  logic                 inj_i,
  input  logic                 inj_mode_i,
  output logic [REG_WIDTH-1:0] value_o,
  output logic                 wrap_o,
  output mism_e                mism_o
);
  localparam bit FT_ON = (FT != 0);
  localparam logic [REG_WIDTH-1:0] ONE = {{(REG_WIDTH-1){1'b0}}, 1'b1};

  logic [REG_WIDTH-1:0] a_q, b_q, c_q, a_d, b_d, c_d;
  logic [REG_WIDTH-1:0] voted, nxt_val;
  logic                 hold, keep, scrub;
  logic                 eq_ab, eq_bc, eq_ac;

  // Bitwise majority of the three copies (copy a alone in single-copy builds).
  always_comb begin
    voted = a_q;
    if (FT_ON) begin
      for (int k = 0; k < REG_WIDTH; k++) begin
        voted[k] = tmr_vote(a_q[k], b_q[k], c_q[k]);
      end
    end
  end

  assign value_o = voted;

  // Classify copy agreement: two-of-three agreeing is correctable.
  always_comb begin
    eq_ab  = (a_q == b_q);
    eq_bc  = (b_q == c_q);
    eq_ac  = (a_q == c_q);
    mism_o = MISM_NONE;
    if (FT_ON) begin
      if (!eq_ab && !eq_bc && !eq_ac) begin
        mism_o = MISM_UNCORR;
      end else if (!(eq_ab && eq_bc)) begin
        mism_o = MISM_CORR;
      end
    end
  end

`ifdef PMU_SCRUB_EN
  assign scrub = (mism_o == MISM_CORR);
`else
  assign scrub = 1'b0;
`endif

  // Next value priority: clear > load > increment > hold.
  always_comb begin
    nxt_val = voted;
    hold    = 1'b0;
    wrap_o  = 1'b0;
    if (clear_i) begin
      nxt_val = '0;
    end else if (wr_en_i) begin
      nxt_val = wr_data_i;
    end else if (inc_i) begin
      nxt_val = voted + ONE;
      wrap_o  = &voted;
    end else begin
      hold = 1'b1;
    end
  end

  // Copies keep their own value on hold (so divergence persists unless
  // scrubbed); injection flips bits after the normal next-value choice.
  always_comb begin
    keep = hold && !scrub;
    a_d  = keep ? a_q : nxt_val;
    b_d  = keep ? b_q : nxt_val;
    c_d  = keep ? c_q : nxt_val;
    if (FT_ON && inj_i) begin
      a_d[0] = ~a_d[0];
      if (inj_mode_i) begin
        b_d[1] = ~b_d[1];
      end
    end
    if (!FT_ON) begin
      b_d = '0;
      c_d = '0;
    end
  end

  // Copy storage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/pmu_counter_bank_ft.sv
// PMU counter bank: event routing, per-counter cells, sticky overflow
// flags and interrupt aggregation.
// Optional macro PMU_SCRUB_EN (effective with FT=1) enables single-fault
// scrubbing inside each counter cell.
module pmu_counter_bank_ft
  import pmu_ft_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int N_COUNTERS = 24,
  parameter int N_EVENTS   = 32,
  parameter int FT         = 0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  pmu_counter_bank_ft_if.slave  bus
);
  localparam int SEL_W = sel_w(N_EVENTS);
  localparam int EXT_W = 1 << SEL_W;

  logic [EXT_W-1:0]                ev_ext;
  logic [SEL_W-1:0]                sel;
  logic [N_COUNTERS-1:0]           inc, wrap;
  logic [N_COUNTERS-1:0]           ovf_d, ovf_q;
  logic [N_COUNTERS*REG_WIDTH-1:0] cnt_val;
  mism_e                           mism [N_COUNTERS];
  logic                            any_corr, any_uncorr;
  logic                            ft1_d, ft1_q, ft2_d, ft2_q;

  // Route the selected event to each counter; out-of-range selects count nothing.
  always_comb begin
    ev_ext                 = '0;
    ev_ext[N_EVENTS-1:0]   = bus.events_i;
    sel                    = '0;
    inc                    = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      sel    = bus.ev_sel_i[i*SEL_W +: SEL_W];
      inc[i] = bus.enable_i && (int'(sel) < N_EVENTS) && ev_ext[sel];
    end
  end

  for (genvar g = 0; g < N_COUNTERS; g++) begin : g_cnt
    pmu_tmr_cnt_cell #(
      .REG_WIDTH (REG_WIDTH),
      .FT        (FT)
    ) u_cell (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .clear_i    (bus.clear_i),
      .wr_en_i    (bus.wr_en_i[g]),
      .wr_data_i  (bus.wr_data_i),
      .inc_i      (inc[g]),
      .inj_i      (bus.ft_inj_i[g]),
      .inj_mode_i (bus.ft_inj_mode_i),
      .value_o    (cnt_val[g*REG_WIDTH +: REG_WIDTH]),
      .wrap_o     (wrap[g]),
      .mism_o     (mism[g])
    );
  end

  // Sticky overflow: clear dominates, a wrap beats a coincident ack.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < N_COUNTERS; i++) begin
      if (bus.clear_i) begin
        ovf_d[i] = 1'b0;
      end else if (wrap[i]) begin
        ovf_d[i] = 1'b1;
      end else if (bus.ovf_ack_i[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  // Sticky FT interrupts: any counter's mismatch sets, ft_clr_i clears, set wins.
  always_comb begin
    any_corr   = 1'b0;
    any_uncorr = 1'b0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      any_corr   = any_corr   | (mism[i] == MISM_CORR);
      any_uncorr = any_uncorr | (mism[i] == MISM_UNCORR);
    end
    ft1_d = any_corr   | (ft1_q & ~bus.ft_clr_i);
    ft2_d = any_uncorr | (ft2_q & ~bus.ft_clr_i);
  end

  // Status registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= '0;
      ft1_q <= 1'b0;
      ft2_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      ft1_q <= ft1_d;
      ft2_q <= ft2_d;
    end
  end

  assign bus.counters_o      = cnt_val;
  assign bus.overflow_o      = ovf_q;
  assign bus.intr_overflow_o = |(ovf_q & bus.ovf_mask_i);
  assign bus.intr_FT1_o      = ft1_q;
  assign bus.intr_FT2_o      = ft2_q;

endmodule

// File: tb/tb_pmu_counter_bank_ft.sv
// Directed bench for pmu_counter_bank_ft built with FT=1.
module tb_pmu_counter_bank_ft;
  localparam int RW = 32;
  localparam int NC = 24;
  localparam int NE = 32;
  localparam int SW = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pmu_counter_bank_ft_if #(.REG_WIDTH(RW), .N_COUNTERS(NC), .N_EVENTS(NE)) bus ();

  pmu_counter_bank_ft #(
    .REG_WIDTH  (RW),
    .N_COUNTERS (NC),
    .N_EVENTS   (NE),
    .FT         (1)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  function automatic logic [RW-1:0] cnt(input int i);
    return bus.counters_o[i*RW +: RW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.events_i      = '0;
    bus.enable_i      = 1'b0;
    bus.clear_i       = 1'b0;
    bus.wr_en_i       = '0;
    bus.wr_data_i     = '0;
    bus.ovf_mask_i    = '0;
    bus.ovf_ack_i     = '0;
    bus.ft_clr_i      = 1'b0;
    bus.ft_inj_i      = '0;
    bus.ft_inj_mode_i = 1'b0;
    for (int i = 0; i < NC; i++) bus.ev_sel_i[i*SW +: SW] = 5'd31;
    bus.ev_sel_i[0*SW +: SW] = 5'd3;
    bus.ev_sel_i[1*SW +: SW] = 5'd4;
    bus.ev_sel_i[2*SW +: SW] = 5'd5;
    bus.ev_sel_i[3*SW +: SW] = 5'd6;

    // Power-on reset
    #23 rstn = 1'b1;
    tick();
    chk("rst_cnt0", cnt(0), 32'd0);
    chk("rst_ovf", {8'd0, bus.overflow_o}, 32'd0);
    chk_b("rst_intr_ovf", bus.intr_overflow_o, 1'b0);
    chk_b("rst_ft1", bus.intr_FT1_o, 1'b0);
    chk_b("rst_ft2", bus.intr_FT2_o, 1'b0);

    // Reset asserted mid-count
    bus.enable_i    = 1'b1;
    bus.events_i[3] = 1'b1;
    tick(7);
    chk("pre_rst_cnt0", cnt(0), 32'd7);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_cnt0", cnt(0), 32'd0);
    bus.events_i[3] = 1'b0;
    #2 rstn = 1'b1;
    tick(3);
    chk("post_rst_cnt0", cnt(0), 32'd0);
    chk("post_rst_ovf", {8'd0, bus.overflow_o}, 32'd0);

    // Five events on counter 0, counter 1 untouched
    bus.events_i[3] = 1'b1;
    tick();
    chk("lat_cnt0", cnt(0), 32'd1);
    tick(4);
    bus.events_i[3] = 1'b0;
    chk("five_cnt0", cnt(0), 32'd5);
    chk("five_cnt1", cnt(1), 32'd0);
    bus.enable_i    = 1'b0;
    bus.events_i[3] = 1'b1;
    tick();
    chk("disabled_cnt0", cnt(0), 32'd5);
    bus.enable_i    = 1'b1;
    bus.events_i[3] = 1'b0;

    // Load near max then wrap on counter 1
    bus.wr_data_i  = 32'hFFFF_FFFE;
    bus.wr_en_i[1] = 1'b1;
    tick();
    bus.wr_en_i[1] = 1'b0;
    chk("load_cnt1", cnt(1), 32'hFFFF_FFFE);
    chk_b("load_no_ovf", bus.overflow_o[1], 1'b0);
    bus.ovf_mask_i[1] = 1'b1;
    bus.events_i[4]   = 1'b1;
    tick();
    chk("max_cnt1", cnt(1), 32'hFFFF_FFFF);
    chk_b("max_no_ovf", bus.overflow_o[1], 1'b0);
    tick();
    bus.events_i[4] = 1'b0;
    chk("wrap_cnt1", cnt(1), 32'd0);
    chk_b("wrap_ovf1", bus.overflow_o[1], 1'b1);
    chk_b("wrap_intr", bus.intr_overflow_o, 1'b1);
    bus.ovf_ack_i[1] = 1'b1;
    tick();
    bus.ovf_ack_i[1] = 1'b0;
    chk_b("ack_ovf1", bus.overflow_o[1], 1'b0);
    chk_b("ack_intr", bus.intr_overflow_o, 1'b0);

    // Wrap coincident with ack: set wins; then mask gating
    bus.wr_data_i  = 32'hFFFF_FFFF;
    bus.wr_en_i[1] = 1'b1;
    tick();
    bus.wr_en_i[1]   = 1'b0;
    bus.events_i[4]  = 1'b1;
    bus.ovf_ack_i[1] = 1'b1;
    tick();
    bus.events_i[4]  = 1'b0;
    bus.ovf_ack_i[1] = 1'b0;
    chk("setack_cnt1", cnt(1), 32'd0);
    chk_b("setack_ovf1", bus.overflow_o[1], 1'b1);
    bus.ovf_mask_i[1] = 1'b0;
    #1;
    chk_b("masked_intr", bus.intr_overflow_o, 1'b0);
    bus.ovf_ack_i[1] = 1'b1;
    tick();
    bus.ovf_ack_i[1] = 1'b0;
    chk_b("ack2_ovf1", bus.overflow_o[1], 1'b0);

    // Clear beats load and event on counter 2 with overflow pending
    bus.wr_data_i  = 32'hFFFF_FFFF;
    bus.wr_en_i[2] = 1'b1;
    tick();
    bus.wr_en_i[2]  = 1'b0;
    bus.events_i[5] = 1'b1;
    tick();
    chk_b("pre_clr_ovf2", bus.overflow_o[2], 1'b1);
    bus.clear_i    = 1'b1;
    bus.wr_en_i[2] = 1'b1;
    bus.wr_data_i  = 32'h55;
    tick();
    bus.clear_i     = 1'b0;
    bus.wr_en_i[2]  = 1'b0;
    bus.events_i[5] = 1'b0;
    chk("clr_cnt2", cnt(2), 32'd0);
    chk_b("clr_ovf2", bus.overflow_o[2], 1'b0);
    chk("clr_cnt0", cnt(0), 32'd0);

    // Single-copy fault on counter 2 = 10
    bus.wr_data_i  = 32'd10;
    bus.wr_en_i[2] = 1'b1;
    tick();
    bus.wr_en_i[2]    = 1'b0;
    bus.ft_inj_i[2]   = 1'b1;
    bus.ft_inj_mode_i = 1'b0;
    tick();
    bus.ft_inj_i[2] = 1'b0;
    chk("inj1_cnt2", cnt(2), 32'd10);
    chk_b("inj1_ft1_early", bus.intr_FT1_o, 1'b0);
    tick();
    chk("inj1_cnt2_hold", cnt(2), 32'd10);
    chk_b("inj1_ft1", bus.intr_FT1_o, 1'b1);
    chk_b("inj1_ft2", bus.intr_FT2_o, 1'b0);
    bus.ft_clr_i = 1'b1;
    tick();
    bus.ft_clr_i = 1'b0;
`ifdef PMU_SCRUB_EN
    chk_b("ftclr_ft1", bus.intr_FT1_o, 1'b0);
`else
    chk_b("ftclr_ft1_persist", bus.intr_FT1_o, 1'b1);
`endif
    bus.events_i[5] = 1'b1;
    tick();
    bus.events_i[5] = 1'b0;
    chk("inj1_inc_cnt2", cnt(2), 32'd11);
    bus.ft_clr_i = 1'b1;
    tick();
    bus.ft_clr_i = 1'b0;
    chk_b("reconv_ft1", bus.intr_FT1_o, 1'b0);
    chk_b("reconv_ft2", bus.intr_FT2_o, 1'b0);
    chk("reconv_cnt2", cnt(2), 32'd11);

    // Double-copy fault on counter 3 = 0
    bus.ft_inj_i[3]   = 1'b1;
    bus.ft_inj_mode_i = 1'b1;
    tick();
    bus.ft_inj_i[3]   = 1'b0;
    bus.ft_inj_mode_i = 1'b0;
    chk("inj2_cnt3", cnt(3), 32'd0);
    chk_b("inj2_ft2_early", bus.intr_FT2_o, 1'b0);
    tick();
    chk_b("inj2_ft2", bus.intr_FT2_o, 1'b1);
    chk_b("inj2_ft1", bus.intr_FT1_o, 1'b0);
    bus.events_i[6] = 1'b1;
    tick(2);
    bus.events_i[6] = 1'b0;
    chk("inj2_inc_cnt3", cnt(3), 32'd2);
    tick();
    chk_b("inj2_ft2_sticky", bus.intr_FT2_o, 1'b1);
    bus.ft_clr_i = 1'b1;
    tick();
    bus.ft_clr_i = 1'b0;
    chk_b("ftclr_ft2", bus.intr_FT2_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmu_counter_bank_ft.md
Name: pmu_counter_bank_ft

Overview:
Parametrised bank of PMU event counters with optional triple-modular-redundant (TMR) storage, per-counter event routing, and sticky overflow/fault interrupts. It is the next-generation counter core instantiated beneath the AHB PMU slave. Register decode stays in the slave; this block owns counting, voting, fault reporting and interrupt generation.

Parameters:
REG_WIDTH, 32, width of each counter.
N_COUNTERS, 24, number of counters.
N_EVENTS, 32, number of selectable SoC events; SEL_W = $clog2(N_EVENTS).
FT, 0, 0 = single copy per counter, 1 = TMR copies with bitwise majority vote.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  reset; asynchronous, active-low.
events_i  in  N_EVENTS  SoC event pulses, one per cycle each.
enable_i  in  1  global count enable.
clear_i  in  1  synchronous clear of all counters and overflow flags.
ev_sel_i  in  N_COUNTERS*SEL_W  event index for each counter.
wr_en_i  in  N_COUNTERS  per-counter load strobe.
wr_data_i  in  REG_WIDTH  load value, shared by all counters.
ovf_mask_i  in  N_COUNTERS  overflow interrupt mask; 1 = enabled.
ovf_ack_i  in  N_COUNTERS  clears the sticky overflow flag.
ft_clr_i  in  1  clears sticky FT interrupts.
ft_inj_i  in  N_COUNTERS  fault-injection strobe.
ft_inj_mode_i  in  1  0 = flip copy0 bit0; 1 = flip copy0 bit0 and copy1 bit1.
counters_o  out  N_COUNTERS*REG_WIDTH  voted counter values.
overflow_o  out  N_COUNTERS  sticky overflow flags.
intr_overflow_o  out  1  OR of (overflow_o & ovf_mask_i).
intr_FT1_o  out  1  sticky: corrected (single-copy) mismatch seen.
intr_FT2_o  out  1  sticky: uncorrectable mismatch seen.

Behaviour:
- Reset: all counter copies, overflow_o, intr_FT1_o and intr_FT2_o are 0. intr_overflow_o is 0 as a consequence.
- inc[i] = enable_i & events_i[ev_sel_i[i]]. An ev_sel_i value >= N_EVENTS selects nothing, so inc[i] = 0.
- Per-counter next-value priority: clear_i (0) > wr_en_i[i] (wr_data_i) > inc[i] (voted+1) > hold.
- Latency: counters_o reflects an event, load or clear one cycle after it is sampled.
- Wrap: incrementing from all-ones gives 0 and sets overflow_o[i] in the same update.
- overflow_o[i] is cleared by clear_i or ovf_ack_i[i]. If set and ack coincide in the same cycle, set wins.
- A load with wr_en_i never sets overflow.
- intr_overflow_o is combinational from the overflow register and ovf_mask_i.
- FT=1:
  - Three copies a, b, c; voted value = (a&b)|(b&c)|(a&c).
  - All copies load the same next value, computed from the voted value.
  - mism1 = any copy differs from the others but at least two copies are equal.
  - mism2 = a!=b & b!=c & a!=c.
  - intr_FT1_o is set the cycle after any counter shows mism1.
  - intr_FT2_o is set the cycle after any counter shows mism2.
  - Both are cleared only by ft_clr_i; set wins over clear.
- Injection: when ft_inj_i[i] is high, the selected bits are XORed into the next value of the chosen copies, after the normal next-value computation. With FT=0, injection, FT1 and FT2 are inert (tied 0).
- Reset mid-operation: asynchronous, immediate, overrides everything.

Optional Feature:
Macro PMU_SCRUB_EN, effective with FT=1.
- With it: a counter showing mism1 writes its voted next value into all three copies, so a single fault is scrubbed in one cycle.
- Without it: divergent copies persist until the next clear or load. Every increment recomputes all copies from the voted value, which also reconverges them.
- With PMU_SCRUB_EN: an injected single fault leaves mism1 true for exactly one cycle.
- Without PMU_SCRUB_EN: mism1 stays true while the counter holds.
- mism2 is never scrubbed.

Decomposition:
- Package pmu_ft_pkg holds:
  - the SEL_W computation;
  - a tmr_vote function;
  - a mismatch-classification enum {MISM_NONE, MISM_CORR, MISM_UNCORR}.
- Sub-module pmu_tmr_cnt_cell holds one counter: copies, next-value mux, injection, scrub, and the mism flags. It is generated N_COUNTERS times.
- The top level handles event selection, the overflow registers and interrupt aggregation.

Test Plan:
1. Reset asserted mid-count with counter 0 = 7 -> all outputs 0 immediately; all stay 0 after release with no events.
2. ev_sel[0]=3, enable_i=1, events_i[3] high for 5 cycles -> counters_o[0]=5 one cycle after the last pulse. Counter 1 (ev_sel=4) stays 0.
3. Load counter 1 = 0xFFFFFFFE, then 2 events with ovf_mask_i[1]=1:
   - values go 0xFFFFFFFF, then 0;
   - overflow_o[1]=1 and intr_overflow_o=1;
   - ovf_ack_i[1] pulse clears both the next cycle.
4. clear_i, wr_en_i[2] (data 0x55) and an event all in the same cycle -> counters_o[2]=0 and overflow_o[2]=0.
5. FT=1, counter 2 = 10, ft_inj_i[2] with mode 0:
   - counters_o[2] stays 10;
   - intr_FT1_o=1 and intr_FT2_o=0;
   - with PMU_SCRUB_EN, mism1 drops after 1 cycle;
   - ft_clr_i clears intr_FT1_o.
6. FT=1, ft_inj_i[3] with mode 1 on counter 3 = 0 -> intr_FT2_o=1 the next cycle and remains set after further events until ft_clr_i.
